// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - MEM stage types, load codes and bus widths
`include "mycpu.vh"

package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = `ES_TO_MS_BUS_WD;
    localparam int MS_TO_WS_BUS_WD = `MS_TO_WS_BUS_WD;
    localparam int MS_TO_DS_BUS_WD = `MS_TO_DS_BUS_WD;

    localparam logic [2:0] LD_W  = `LD_TYPE_W;
    localparam logic [2:0] LD_B  = `LD_TYPE_B;
    localparam logic [2:0] LD_BU = `LD_TYPE_BU;
    localparam logic [2:0] LD_H  = `LD_TYPE_H;
    localparam logic [2:0] LD_HU = `LD_TYPE_HU;

    // Response tracking for the single outstanding data request
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ms_state_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - byte/half selection and extension of load data
`include "mycpu.vh"

module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half; addr[0] does not matter for halves
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend according to load type; unused codes fall back to a word load
    always_comb begin
        result = rdata;
        case (ld_type)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mycpu.vh
// rtl/mycpu.vh - shared pipeline bus widths and load-type codes
`ifndef MYCPU_VH
`define MYCPU_VH

`define ES_TO_MS_BUS_WD 75
`define MS_TO_WS_BUS_WD 70
`define MS_TO_DS_BUS_WD 39

`define LD_TYPE_W  3'd0
`define LD_TYPE_B  3'd1
`define LD_TYPE_BU 3'd2
`define LD_TYPE_H  3'd3
`define LD_TYPE_HU 3'd4

`endif

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with data response tracking
`include "mycpu.vh"

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    output logic                        ms_allowin,
    input  logic                        es_to_ms_valid,
    input  logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                        ws_allowin,
    output logic                        ms_to_ws_valid,
    output logic [`MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [`MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                        data_sram_data_ok,
    input  logic [31:0]                 data_sram_rdata
);

    logic                        ms_valid;
    logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;

    logic        res_from_mem;
    logic [2:0]  ld_type;
    logic        mem_req;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    ms_state_e   state;
    ms_state_e   state_next;
    logic        buf_valid;
    logic [31:0] buf_data;

    logic        data_ok;
    logic        ms_ready_go;
    logic        accept;
    logic        new_mem_req;
    logic        leave;
    logic [31:0] load_data;
    logic [31:0] aligned_data;
    logic [31:0] final_result;
    logic        fwd_valid;
    logic        fwd_blocked;

    assign {res_from_mem, ld_type, mem_req, gr_we, dest, alu_result, pc} = es_to_ms_bus_r;

    // A response only belongs to us while a request is actually outstanding
    assign data_ok     = data_sram_data_ok && (state == S_WAIT);
    assign ms_ready_go = !mem_req || data_ok || buf_valid;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign accept      = es_to_ms_valid && ms_allowin;
    assign new_mem_req = accept && es_to_ms_bus[70];
    assign leave       = ms_to_ws_valid && ws_allowin;

    // Pipeline valid bit
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Instruction payload; contents only matter while ms_valid is set
    always_ff @(posedge clk) begin
        if (accept) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

    // Response FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response FSM next state; a new memory instruction always restarts WAIT
    always_comb begin
        state_next = state;
        if (new_mem_req) begin
            state_next = S_WAIT;
        end else begin
            case (state)
                S_WAIT: begin
                    if (data_ok && !ws_allowin) begin
                        state_next = S_HOLD;
                    end else if (data_ok) begin
                        state_next = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (ws_allowin) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Park the response when WB stalls; released when the instruction retires
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
        end else if (leave) begin
            buf_valid <= 1'b0;
        end else if (data_ok && !ws_allowin) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    assign load_data = buf_valid ? buf_data : data_sram_rdata;

    load_align u_load_align (
        .ld_type (ld_type),
        .addr    (alu_result[1:0]),
        .rdata   (load_data),
        .result  (aligned_data)
    );

    assign final_result = res_from_mem ? aligned_data : alu_result;

    assign fwd_valid   = ms_valid && gr_we && (dest != 5'd0);
    assign fwd_blocked = fwd_valid && res_from_mem && !ms_ready_go;

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign ms_to_ds_bus = {fwd_valid, fwd_blocked, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_to_ds_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    int xfers    = 0;
    int xfers_start;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) xfers <= xfers + 1;
    end

    function automatic logic [74:0] mk(input logic rfm, input logic [2:0] lt, input logic mr,
                                       input logic gw, input logic [4:0] d,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {rfm, lt, mr, gw, d, alu, pc};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] lt, input logic [31:0] alu,
                           input logic [31:0] rd, input logic [31:0] exp);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b1, lt, 1'b1, 1'b1, 5'd10, alu, 32'h1c000100);
        #1;
        step();
        es_to_ms_valid = 1'b0;
        #1;
        chk({tag, "_blocked"}, 70'(ms_to_ds_bus[37]), 70'd1);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        chk({tag, "_valid"}, 70'(ms_to_ws_valid), 70'd1);
        chk({tag, "_result"}, 70'(ms_to_ws_bus[63:32]), 70'(exp));
        step();
        data_sram_data_ok = 1'b0;
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_valid",   70'(ms_to_ws_valid), 70'd0);
        chk("rst_allowin", 70'(ms_allowin), 70'd1);
        chk("rst_fwd",     70'(ms_to_ds_bus[38:37]), 70'd0);

        // ALU instruction: one cycle through MEM
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd3, 32'h5, 32'h1c000000);
        #1;
        step();
        es_to_ms_valid = 1'b0;
        #1;
        chk("add_valid", 70'(ms_to_ws_valid), 70'd1);
        chk("add_bus",   ms_to_ws_bus, {1'b1, 5'd3, 32'h00000005, 32'h1c000000});
        chk("add_fwd",   70'(ms_to_ds_bus[38:37]), 70'b10);
        step();
        chk("add_gone",  70'(ms_to_ws_valid), 70'd0);

        // LD.B at byte 3 with three wait cycles before data_ok
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b1, 3'd1, 1'b1, 1'b1, 5'd4, 32'h10000003, 32'h1c000004);
        #1;
        step();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldb_wait_valid",   70'(ms_to_ws_valid), 70'd0);
            chk("ldb_wait_blocked", 70'(ms_to_ds_bus[37]), 70'd1);
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF1234;
        #1;
        chk("ldb_valid",   70'(ms_to_ws_valid), 70'd1);
        chk("ldb_result",  70'(ms_to_ws_bus[63:32]), 70'(32'hFFFFFF80));
        chk("ldb_blocked", 70'(ms_to_ds_bus[37]), 70'd0);
        step();
        data_sram_data_ok = 1'b0;
        #1;
        chk("ldb_gone",  70'(ms_to_ws_valid), 70'd0);
        chk("ldb_idle",  70'(dut.state), 70'(S_IDLE));

        // LD.HU with WB stalled for two cycles when data arrives
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b1, 3'd4, 1'b1, 1'b1, 5'd5, 32'h20000002, 32'h1c000008);
        #1;
        step();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF0000;
        xfers_start       = xfers;
        #1;
        chk("ldhu_allowin", 70'(ms_allowin), 70'd0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h12345678;
        #1;
        chk("ldhu_hold",   70'(dut.state), 70'(S_HOLD));
        chk("ldhu_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h0000BEEF));
        step();
        data_sram_data_ok = 1'b1;
        #1;
        chk("ldhu_hold2",  70'(dut.state), 70'(S_HOLD));
        chk("ldhu_valid",  70'(ms_to_ws_valid), 70'd1);
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
        #1;
        chk("ldhu_rel_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h0000BEEF));
        step();
        chk("ldhu_gone",  70'(ms_to_ws_valid), 70'd0);
        chk("ldhu_idle",  70'(dut.state), 70'(S_IDLE));
        chk("ldhu_xfers", 70'(xfers - xfers_start), 70'd1);

        // Back-to-back loads: retire and accept in the same cycle
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd6, 32'h30000000, 32'h1c00000c);
        #1;
        step();
        es_to_ms_bus      = mk(1'b1, 3'd1, 1'b1, 1'b1, 5'd7, 32'h30000004, 32'h1c000010);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFEF00D;
        #1;
        chk("b2b_a_valid",   70'(ms_to_ws_valid), 70'd1);
        chk("b2b_a_bus",     ms_to_ws_bus, {1'b1, 5'd6, 32'hCAFEF00D, 32'h1c00000c});
        chk("b2b_allowin",   70'(ms_allowin), 70'd1);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        chk("b2b_wait",      70'(dut.state), 70'(S_WAIT));
        chk("b2b_b_pending", 70'(ms_to_ws_valid), 70'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000007F;
        #1;
        chk("b2b_b_bus",     ms_to_ws_bus, {1'b1, 5'd7, 32'h0000007F, 32'h1c000010});
        step();
        data_sram_data_ok = 1'b0;
        #1;

        // Reset while waiting drops the load; a late data_ok is ignored
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd8, 32'h40000000, 32'h1c000014);
        #1;
        step();
        es_to_ms_valid = 1'b0;
        reset          = 1'b1;
        step();
        reset             = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55555555;
        #1;
        chk("rstw_valid",   70'(ms_to_ws_valid), 70'd0);
        chk("rstw_allowin", 70'(ms_allowin), 70'd1);
        step();
        data_sram_data_ok = 1'b0;
        #1;
        chk("rstw_idle",    70'(dut.state), 70'(S_IDLE));
        chk("rstw_valid2",  70'(ms_to_ws_valid), 70'd0);

        // Store: held until data_ok, not forwarded, rdata discarded
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 3'd0, 1'b1, 1'b0, 5'd9, 32'h50000008, 32'h1c000018);
        #1;
        step();
        es_to_ms_valid = 1'b0;
        #1;
        chk("st_wait_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("st_fwd",        70'(ms_to_ds_bus[38:37]), 70'd0);
        chk("st_allowin",    70'(ms_allowin), 70'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        #1;
        chk("st_bus",        ms_to_ws_bus, {1'b0, 5'd9, 32'h50000008, 32'h1c000018});
        chk("st_valid",      70'(ms_to_ws_valid), 70'd1);
        step();
        data_sram_data_ok = 1'b0;
        #1;
        chk("st_gone",       70'(ms_to_ws_valid), 70'd0);

        // Remaining alignment cases
        do_load("ldh_a3",  3'd3, 32'h60000003, 32'h80015555, 32'hFFFF8001);
        do_load("ldh_a0",  3'd3, 32'h60000000, 32'h0000F00F, 32'hFFFFF00F);
        do_load("ldbu_a1", 3'd2, 32'h60000001, 32'h00009A00, 32'h0000009A);
        do_load("ld5_w",   3'd5, 32'h60000001, 32'h12345678, 32'h12345678);
        do_load("ld7_w",   3'd7, 32'h60000002, 32'h87654321, 32'h87654321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 ms_allowin  output  1  MEM can accept a new instruction from EXE this cycle.
REQ-004 es_to_ms_valid  input  1  EXE presents a valid instruction.
REQ-005 es_to_ms_bus  input  `ES_TO_MS_BUS_WD (75)  {res_from_mem[74], ld_type[73:71], mem_req[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-006 ws_allowin  input  1  WB accepts this cycle.
REQ-007 ms_to_ws_valid  output  1  MEM presents a completed instruction to WB.
REQ-008 ms_to_ws_bus  output  `MS_TO_WS_BUS_WD (70)  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-009 ms_to_ds_bus  output  39  {fwd_valid[38], fwd_blocked[37], dest[36:32], final_result[31:0]} for decode bypass/interlock.
REQ-010 data_sram_data_ok  input  1  read/write response for the oldest outstanding data request.
REQ-011 data_sram_rdata  input  32  load data; valid only when data_sram_data_ok=1.

Function
REQ-012 ms_valid SHALL load es_to_ms_valid when ms_allowin=1, else hold; es_to_ms_bus SHALL be registered only when es_to_ms_valid && ms_allowin.
REQ-013 ms_allowin SHALL equal !ms_valid || (ms_ready_go && ws_allowin).
REQ-014 ms_ready_go SHALL equal !mem_req || data_ok || buf_valid; ms_to_ws_valid SHALL equal ms_valid && ms_ready_go.
REQ-015 Response FSM SHALL have states IDLE, WAIT, HOLD: IDLE->WAIT on acceptance with mem_req=1; WAIT->HOLD on data_ok with ws_allowin=0; WAIT->IDLE on data_ok with ws_allowin=1 and no new mem_req accepted; HOLD->IDLE on ws_allowin; any->WAIT on same-cycle handoff to a new mem_req instruction.
REQ-016 In WAIT with data_ok=1 and ws_allowin=0, data_sram_rdata SHALL be captured into a 32-bit buffer and buf_valid set; buf_valid SHALL clear when the instruction leaves MEM.
REQ-017 data_ok and ws_allowin in the same cycle SHALL pass rdata straight through with zero added latency; no buffering.
REQ-018 data_sram_data_ok SHALL be ignored in IDLE and HOLD (stores still complete via data_ok in WAIT; their rdata is discarded).
REQ-019 Load select by alu_result[1:0]: ld_type 0=W (whole word), 1=B sign-ext byte, 2=BU zero-ext byte, 3=H sign-ext half at addr[1], 4=HU zero-ext half at addr[1]; codes 5-7 SHALL behave as W; addr[0] is ignored for H/HU.
REQ-020 final_result SHALL be the aligned load data when res_from_mem=1, else alu_result.
REQ-021 fwd_valid SHALL be ms_valid && gr_we && dest!=0; fwd_blocked SHALL be fwd_valid && res_from_mem && !ms_ready_go.
REQ-022 Latency: non-memory instruction 1 cycle EXE->WB; load = cycles until data_ok, plus WB stall cycles.

Reset
REQ-023 On reset: ms_valid=0, state=IDLE, buf_valid=0; hence ms_to_ws_valid=0, ms_allowin=1, fwd_valid=0, fwd_blocked=0 from the next cycle.
REQ-024 Reset during WAIT or HOLD SHALL drop the instruction; a data_ok arriving after reset SHALL be ignored (REQ-018).
REQ-025 The bus payload register is not reset; its contents are don't-care while ms_valid=0.

Structure
REQ-026 `ES_TO_MS_BUS_WD, `MS_TO_WS_BUS_WD, `MS_TO_DS_BUS_WD and the ld_type codes SHALL be defined in mycpu.vh.
REQ-027 Load alignment/extension SHALL be a combinational sub-module load_align (inputs ld_type, addr[1:0], rdata; output 32-bit result).

Verification
REQ-028 ADD pc=0x1c000000, alu_result=0x5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus={1,dest,0x00000005,0x1c000000}.
REQ-029 LD.B addr low bits 2'b11, rdata=0x80FF1234, data_ok 3 cycles after acceptance -> ms_to_ws_valid rises in the data_ok cycle; final_result=0xFFFFFF80; fwd_blocked=1 during the 3 wait cycles.
REQ-030 LD.HU addr bits 2'b10, rdata=0xBEEF0000, data_ok while ws_allowin=0 for 2 cycles -> state HOLD, buffered; on release final_result=0x0000BEEF, exactly one transfer.
REQ-031 Back-to-back loads, data_ok and ws_allowin both 1 -> first retires, second accepted the same cycle, FSM stays WAIT, no data loss.
REQ-032 Reset asserted in WAIT, then data_ok pulse -> ms_to_ws_valid stays 0, ms_allowin=1.
REQ-033 Store (mem_req=1, gr_we=0) -> held until data_ok; forwarded with fwd_valid=0; rdata ignored.
